// File: rtl/fifo_rd_pkg.sv
// Shared constants and pointer helper for the FIFO read-side stream adapter.
// Only fifo_stream_reader uses the optional FIFO_RD_LAST_EN build macro; nothing here depends on it.
package fifo_rd_pkg;

    localparam int SKID_DEPTH = 3;
    localparam int LEVEL_W    = 2;
    localparam int PTR_W      = $clog2(SKID_DEPTH);

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [PTR_W-1:0]   ptr_t;

    // Circular pointer advance over a non-power-of-two depth.
    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry circular skid store: tail push, head pop, head data and occupancy.
// A pop while empty is ignored. Push-when-full is prevented by the caller's read throttle.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [LEVEL_W-1:0] level
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    ptr_t             head;
    ptr_t             tail;
    level_t           count;
    logic             do_pop;

    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= din;
                tail      <= ptr_next(tail);
            end
            if (do_pop) begin
                head <= ptr_next(head);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[head];
    assign level = count;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side adapter from a registered-output synchronous FIFO to a valid/ready stream.
// Optional build macro FIFO_RD_LAST_EN adds BURST_LEN framing on m_last; otherwise m_last is 0.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_ren,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [LEVEL_W-1:0]    level
);

    logic inflight;
    logic pop;

    // Reserve a slot for every word already requested so the skid store never overflows.
    assign fifo_ren = !rst && !fifo_empty &&
                      (({1'b0, level} + {2'b00, inflight}) < 3'(SKID_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_ren;
        end
    end

    assign m_valid = (level != '0);
    assign pop     = m_valid && m_ready;

    fifo_rd_skid_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (fifo_dout),
        .dout  (m_data),
        .level (level)
    );

`ifdef FIFO_RD_LAST_EN
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    if (BURST_LEN < 1) begin : g_bad_burst
        $error("BURST_LEN must be at least 1");
    end

    logic [CNT_W-1:0] burst_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (pop) begin
            burst_cnt <= (burst_cnt == CNT_W'(BURST_LEN - 1)) ? '0 : burst_cnt + 1'b1;
        end
    end

    assign m_last = m_valid && (burst_cnt == CNT_W'(BURST_LEN - 1));
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with a behavioural registered-output FIFO.
// Build with or without FIFO_RD_LAST_EN; m_last expectations follow the macro.
module tb_fifo_stream_reader;

    localparam int W  = 16;
    localparam int BL = 4;

    logic          clk;
    logic          rst;
    logic          fifo_ren;
    logic          fifo_empty;
    logic [W-1:0]  fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic [1:0]    level;

    fifo_stream_reader #(
        .FIFO_WIDTH (W),
        .BURST_LEN  (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_ren   (fifo_ren),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural FIFO sharing rst: reset discards anything still unread.
    logic [W-1:0] fifo_mem [1024];
    logic [9:0]   wr_ptr = '0;
    logic [9:0]   rd_ptr = '0;
    logic [W-1:0] exp_q [$];

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= wr_ptr;
            fifo_dout <= '0;
        end else if (fifo_ren) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 10'd1;
        end
    end

    task automatic applyStimulus(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr] = base + W'(i);
            exp_q.push_back(base + W'(i));
            wr_ptr = wr_ptr + 10'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle scoreboard and protocol checks, sampled mid-cycle.
    int         hs_count     = 0;
    int         hs_since_rst = 0;
    logic [7:0] last_mask    = '0;
    logic       prev_hold    = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic       prev_ren     = 1'b0;
    logic [1:0] prev_level   = '0;
    logic       prev_hs      = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            hs_since_rst <= 0;
            last_mask    <= '0;
        end else begin
            checkOutput("ren_while_empty", 32'(fifo_ren && fifo_empty), 32'd0);
            checkOutput("push_at_full", 32'(prev_ren && (prev_level == 2'd3) && !prev_hs), 32'd0);
`ifdef FIFO_RD_LAST_EN
            checkOutput("m_last", 32'(m_last),
                        32'(m_valid && ((hs_since_rst % BL) == BL - 1)));
`else
            checkOutput("m_last_off", 32'(m_last), 32'd0);
`endif
            if (prev_hold) begin
                checkOutput("valid_held", 32'(m_valid), 32'd1);
                checkOutput("data_stable", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("order", 32'(m_data), 32'(exp_q.pop_front()));
                end
                if (hs_since_rst < 8) begin
                    last_mask[hs_since_rst[2:0]] <= m_last;
                end
                hs_count     <= hs_count + 1;
                hs_since_rst <= hs_since_rst + 1;
            end
        end
        prev_hold  <= !rst && m_valid && !m_ready;
        prev_data  <= m_data;
        prev_ren   <= fifo_ren;
        prev_level <= level;
        prev_hs    <= !rst && m_valid && m_ready;
    end

    // Expected per-cycle waveform for four preloaded words with m_ready high.
    logic         t1_ren   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         t1_valid [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] t1_data  [7] = '{16'h0, 16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h0};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hs0;
        int n;
        logic [7:0] exp_mask;

        rst     = 1'b1;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ren",   32'(fifo_ren), 32'd0);
        checkOutput("rst_valid", 32'(m_valid),  32'd0);
        checkOutput("rst_data",  32'(m_data),   32'd0);
        checkOutput("rst_last",  32'(m_last),   32'd0);
        checkOutput("rst_level", 32'(level),    32'd0);
        tick();
        rst = 1'b0;

        // Preloaded 4 words, consumer always ready.
        tick();
        m_ready = 1'b1;
        applyStimulus(4, 16'h0001);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t1_ren_c%0d", c), 32'(fifo_ren), 32'(t1_ren[c]));
            checkOutput($sformatf("t1_valid_c%0d", c), 32'(m_valid), 32'(t1_valid[c]));
            if (t1_valid[c]) begin
                checkOutput($sformatf("t1_data_c%0d", c), 32'(m_data), 32'(t1_data[c]));
            end
        end

        // Backpressure from the start: exactly three reads, then full drain at one per cycle.
        tick();
        m_ready = 1'b0;
        applyStimulus(10, 16'h0001);
        n = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (fifo_ren) n++;
        end
        checkOutput("t2_ren_count", 32'(n), 32'd3);
        checkOutput("t2_level", 32'(level), 32'd3);
        checkOutput("t2_valid", 32'(m_valid), 32'd1);
        checkOutput("t2_head", 32'(m_data), 32'h0001);
        tick();
        m_ready = 1'b1;
        hs0 = hs_count;
        repeat (10) tick();
        checkOutput("t2_drain_count", 32'(hs_count - hs0), 32'd10);
        @(negedge clk);
        checkOutput("t2_valid_after", 32'(m_valid), 32'd0);
        checkOutput("t2_level_after", 32'(level), 32'd0);

        // 100 words with m_ready toggling every cycle.
        tick();
        hs0 = hs_count;
        m_ready = 1'b0;
        applyStimulus(100, 16'h1000);
        for (int i = 0; i < 1000 && (hs_count - hs0) < 100; i++) begin
            tick();
            m_ready = ~m_ready;
        end
        checkOutput("t3_count", 32'(hs_count - hs0), 32'd100);
        checkOutput("t3_left", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b1;

        // Writer stall: FIFO drains, stream stops, then resumes in order.
        tick();
        hs0 = hs_count;
        applyStimulus(3, 16'h2000);
        repeat (10) tick();
        @(negedge clk);
        checkOutput("t4_valid_idle", 32'(m_valid), 32'd0);
        checkOutput("t4_level_idle", 32'(level), 32'd0);
        checkOutput("t4_ren_idle", 32'(fifo_ren), 32'd0);
        tick();
        applyStimulus(3, 16'h2100);
        repeat (10) tick();
        checkOutput("t4_count", 32'(hs_count - hs0), 32'd6);
        checkOutput("t4_left", 32'(exp_q.size()), 32'd0);

        // Reset while a read is in flight and two words are buffered.
        m_ready = 1'b0;
        applyStimulus(5, 16'h3000);
        repeat (3) tick();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("t5_level_pre", 32'(level), 32'd2);
        checkOutput("t5_ren_in_rst", 32'(fifo_ren), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_valid_post", 32'(m_valid), 32'd0);
        checkOutput("t5_level_post", 32'(level), 32'd0);
        tick();
        applyStimulus(2, 16'hA001);
        n = 0;
        for (int c = 0; c < 10 && n == 0; c++) begin
            @(negedge clk);
            if (m_valid) n = 1;
        end
        checkOutput("t5_valid_seen", 32'(n), 32'd1);
        checkOutput("t5_first_word", 32'(m_data), 32'hA001);
        tick();
        m_ready = 1'b1;
        repeat (5) tick();
        checkOutput("t5_left", 32'(exp_q.size()), 32'd0);

        // Burst framing over 8 words right after reset.
        rst = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        hs0 = hs_count;
        applyStimulus(8, 16'h4000);
        repeat (14) tick();
        checkOutput("t6_count", 32'(hs_count - hs0), 32'd8);
`ifdef FIFO_RD_LAST_EN
        exp_mask = 8'h88;
`else
        exp_mask = 8'h00;
`endif
        checkOutput("t6_last_mask", 32'(last_mask), 32'(exp_mask));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for the team's synchronous FIFO. It drives the FIFO read port (read enable, empty flag, one-cycle registered read data) and presents the words as a valid/ready stream with full throughput and no loss under backpressure. It sits between the FIFO and any streaming consumer, absorbing the FIFO's read latency in a small skid buffer.

## Interface
- FIFO_WIDTH, 16, data word width; must match the FIFO.
- BURST_LEN, 8, words per burst for m_last framing (used only with FIFO_RD_LAST_EN); must be ≥1.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fifo_ren  out  1  FIFO read enable.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  FIFO_WIDTH  FIFO registered read data, valid the cycle after fifo_ren.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer ready.
- m_data  out  FIFO_WIDTH  output word.
- m_last  out  1  last word of a BURST_LEN group (0 when macro off).
- level  out  2  skid buffer occupancy, 0..3.

## Operation
- Skid buffer: 3 entries, circular, with head/tail pointers and an occupancy count.
- inflight: 1-bit register, set in the cycle after fifo_ren=1. In that cycle fifo_dout is written into the buffer at the tail.
- fifo_ren = !rst && !fifo_empty && (level + inflight < 3). It is combinational from registered state and fifo_empty only, with no path from m_ready.
- Never assert fifo_ren while fifo_empty=1.
- m_valid = (level != 0). m_data is the head entry.
- Pop on m_valid && m_ready. Push and pop in the same cycle leave level unchanged.
- Order is strictly FIFO. No drop, no duplication.
- Overflow is impossible by construction. Verification asserts that level never exceeds 3 and that no push occurs at level=3 without a same-cycle pop.
- A held m_valid is never retracted. m_data stays stable until accepted.

## Timing
- Reset values: fifo_ren=0, m_valid=0, m_data=0, m_last=0, level=0, inflight=0, burst counter=0.
- Latency: fifo_ren high in cycle c gives a buffer write at the end of c+1, and m_valid=1 in c+2 with that word.
- Throughput: with m_ready held high and the FIFO non-empty, one word per cycle is sustained after the initial 2-cycle fill.
- With m_ready low from the start, exactly 3 reads are issued and then fifo_ren stays low.
- Reset mid-operation: any in-flight word is discarded and the buffer is emptied. The FIFO shares rst, so no stale data survives.
- fifo_empty rising while a read is in flight: the in-flight word is still captured, and no further reads are issued.

## Configuration
- FIFO_RD_LAST_EN defined:
  - A burst counter (width $clog2(BURST_LEN)+1) increments on each handshake and wraps to 0 after BURST_LEN-1.
  - m_last = m_valid && (count == BURST_LEN-1).
  - The counter resets to 0.
- Not defined: the counter is not built and m_last is tied to 0.

## Structure
- Shared package fifo_rd_pkg holds these constants:
  - SKID_DEPTH=3.
  - LEVEL_W=2.
  - Pointer width for the skid buffer.
- Sub-module fifo_rd_skid_buf holds the 3-entry circular store: push, pop, head data and level. The top contains the fifo_ren/inflight control and the burst framing.

## Test plan
- Reset, FIFO preloaded with 0x0001..0x0004, m_ready=1: first fifo_ren in cycle c, then m_valid from c+2 carrying 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles. m_valid falls after 0x0004, and fifo_ren is never high while empty.
- FIFO holds 10 words, m_ready=0: fifo_ren is high for exactly 3 cycles, level=3, and m_data holds 0x0001 stable. Releasing m_ready yields the 10 words in order at 1 per cycle.
- 100 words with m_ready toggling every cycle: all 100 are received in order, with no loss or duplication.
- Writer stalls so the FIFO goes empty mid-stream: fifo_ren=0 while empty, m_valid drops after the buffer drains, and the stream resumes in order after new writes.
- rst asserted for 1 cycle while inflight=1 and level=2: the next cycle has m_valid=0, level=0, and the first word after reset is the first word written post-reset.
- FIFO_RD_LAST_EN, BURST_LEN=4, 8 words: m_last is high with words 4 and 8 only. Without the macro, m_last=0 throughout.
